// File: rtl/alu_result_fifo.sv
// Four-entry show-ahead FIFO buffering ALU results with per-entry zero/neg flags.
// Optional macro ALU_RESULT_PARITY_EN adds a stored even-parity bit on output `parity`.
module alu_result_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_in,
    input  logic [1:0] ctrl_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] s_out,
    output logic [1:0] ctrl_out,
    output logic       zero,
    output logic       neg,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] count,
    output logic       bad_sel
`ifdef ALU_RESULT_PARITY_EN
    ,
    output logic       parity
`endif
);

    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_nxt;
    logic [PTR_W-1:0]   wr_nxt;
    logic [CNT_W-1:0]   count_nxt;
    logic               push;
    logic               pop;
    logic               head_bypass;
    logic               zero_in;
    logic               neg_in;

    logic [7:0]         mem_s    [DEPTH];
    logic [1:0]         mem_ctrl [DEPTH];
    logic               mem_zero [DEPTH];
    logic               mem_neg  [DEPTH];
`ifdef ALU_RESULT_PARITY_EN
    logic               mem_par  [DEPTH];
    logic               par_in;
    assign par_in = ^s_in;
`endif

    // Ready depends on occupancy alone, so a full buffer never accepts on a same-cycle pop.
    assign in_ready = (count < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready && (ctrl_in != 2'b11);
    assign pop      = out_valid && out_ready;
    assign zero_in  = (s_in == 8'h00);
    assign neg_in   = s_in[7];

    // Next-state, pointer and occupancy computation.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        rd_nxt    = rd_ptr;
        wr_nxt    = wr_ptr;
        if (push) begin
            wr_nxt = wr_ptr + PTR_W'(1);
        end
        if (pop) begin
            rd_nxt = rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
        case (state)
            EMPTY:   if (push) state_nxt = ACTIVE;
            ACTIVE: begin
                if (push && !pop && count == CNT_W'(3)) begin
                    state_nxt = FULL;
                end else if (pop && !push && count == CNT_W'(1)) begin
                    state_nxt = EMPTY;
                end
            end
            FULL:    if (pop) state_nxt = ACTIVE;
            default: state_nxt = EMPTY;
        endcase
        // Next head is the entry being written when everything older has drained.
        head_bypass = push && (rd_nxt == wr_ptr);
    end

    // Storage needs no reset; occupancy tracking guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_s[wr_ptr]    <= s_in;
            mem_ctrl[wr_ptr] <= ctrl_in;
            mem_zero[wr_ptr] <= zero_in;
            mem_neg[wr_ptr]  <= neg_in;
`ifdef ALU_RESULT_PARITY_EN
            mem_par[wr_ptr]  <= par_in;
`endif
        end
    end

    // State, pointers and registered head outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            bad_sel   <= 1'b0;
            out_valid <= 1'b0;
            s_out     <= '0;
            ctrl_out  <= '0;
            zero      <= 1'b0;
            neg       <= 1'b0;
`ifdef ALU_RESULT_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            rd_ptr    <= rd_nxt;
            wr_ptr    <= wr_nxt;
            bad_sel   <= bad_sel | (in_valid && in_ready && (ctrl_in == 2'b11));
            out_valid <= (state_nxt != EMPTY);
            if (state_nxt == EMPTY) begin
                s_out    <= '0;
                ctrl_out <= '0;
                zero     <= 1'b0;
                neg      <= 1'b0;
`ifdef ALU_RESULT_PARITY_EN
                parity   <= 1'b0;
`endif
            end else if (head_bypass) begin
                s_out    <= s_in;
                ctrl_out <= ctrl_in;
                zero     <= zero_in;
                neg      <= neg_in;
`ifdef ALU_RESULT_PARITY_EN
                parity   <= par_in;
`endif
            end else begin
                s_out    <= mem_s[rd_nxt];
                ctrl_out <= mem_ctrl[rd_nxt];
                zero     <= mem_zero[rd_nxt];
                neg      <= mem_neg[rd_nxt];
`ifdef ALU_RESULT_PARITY_EN
                parity   <= mem_par[rd_nxt];
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: negedge scoreboard plus directed scenario checks.
module tb_alu_result_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] s_in;
    logic [1:0] ctrl_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] s_out;
    logic [1:0] ctrl_out;
    logic       zero;
    logic       neg;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       bad_sel;
`ifdef ALU_RESULT_PARITY_EN
    logic       parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] sb_q [$];   // {ctrl, s} in expected pop order
    logic       bad_m;

    alu_result_fifo #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_in      (s_in),
        .ctrl_in   (ctrl_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s_out     (s_out),
        .ctrl_out  (ctrl_out),
        .zero      (zero),
        .neg       (neg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .bad_sel   (bad_sel)
`ifdef ALU_RESULT_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: check outputs against the model, then advance the model for the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            bad_m = 1'b0;
        end else begin
            int sz;
            logic [9:0] hd;
            sz = sb_q.size();
            check_eq("count", 32'(count), 32'(sz));
            check_eq("in_ready", 32'(in_ready), 32'(sz < 4));
            check_eq("out_valid", 32'(out_valid), 32'(sz != 0));
            check_eq("bad_sel", 32'(bad_sel), 32'(bad_m));
            hd = (sz != 0) ? sb_q[0] : 10'h000;
            check_eq("s_out", 32'(s_out), 32'(hd[7:0]));
            check_eq("ctrl_out", 32'(ctrl_out), 32'(hd[9:8]));
            check_eq("zero", 32'(zero), 32'((sz != 0) && (hd[7:0] == 8'h00)));
            check_eq("neg", 32'(neg), 32'((sz != 0) && hd[7]));
`ifdef ALU_RESULT_PARITY_EN
            check_eq("parity", 32'(parity), 32'((sz != 0) && (^hd[7:0])));
`endif
            if (out_ready && sz != 0) void'(sb_q.pop_front());
            if (in_valid && sz < 4 && ctrl_in != 2'b11) sb_q.push_back({ctrl_in, s_in});
            if (in_valid && sz < 4 && ctrl_in == 2'b11) bad_m = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] s, input logic [1:0] c, input logic r);
        in_valid  = v;
        s_in      = s;
        ctrl_in   = c;
        out_ready = r;
        step();
    endtask

    initial begin
        logic [7:0] v35 [4];
        v35 = '{8'h81, 8'h02, 8'h7F, 8'hFF};
        rst = 1'b1; in_valid = 1'b0; s_in = '0; ctrl_in = '0; out_ready = 1'b0;
        #2;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_bad_sel", 32'(bad_sel), 32'd0);
        step();
        rst = 1'b0;

        // Single zero-valued push appears one cycle later.
        drive(1'b1, 8'h00, 2'b00, 1'b0);
        check_eq("r34_valid", 32'(out_valid), 32'd1);
        check_eq("r34_s", 32'(s_out), 32'h00);
        check_eq("r34_zero", 32'(zero), 32'd1);
        check_eq("r34_neg", 32'(neg), 32'd0);
        check_eq("r34_count", 32'(count), 32'd1);
        drive(1'b0, 8'h00, 2'b00, 1'b1);
        check_eq("r34_drained", 32'(count), 32'd0);

        // Fill, reject a fifth offer, drain in order.
        for (int i = 0; i < 4; i++) drive(1'b1, v35[i], 2'b10, 1'b0);
        check_eq("r35_full", 32'(count), 32'd4);
        check_eq("r35_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 8'hAA, 2'b10, 1'b0);
        check_eq("r35_5th_ignored", 32'(count), 32'd4);
        check_eq("r35_head_neg", 32'(neg), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq("r35_order", 32'(s_out), 32'(v35[i]));
            drive(1'b0, 8'h00, 2'b00, 1'b1);
        end
        check_eq("r35_empty", 32'(count), 32'd0);

        // Simultaneous push/pop at count 2 across pointer wrap.
        drive(1'b1, 8'h10, 2'b01, 1'b0);
        drive(1'b1, 8'h11, 2'b01, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(8'h20 + i), 2'b01, 1'b1);
            check_eq("r36_count", 32'(count), 32'd2);
        end
        drive(1'b0, 8'h00, 2'b00, 1'b1);
        drive(1'b0, 8'h00, 2'b00, 1'b1);

        // Illegal select is dropped and latches bad_sel.
        drive(1'b1, 8'h55, 2'b11, 1'b0);
        check_eq("r37_count", 32'(count), 32'd0);
        check_eq("r37_bad", 32'(bad_sel), 32'd1);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 2'b00, 1'b0);
        check_eq("r37_sticky", 32'(bad_sel), 32'd1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(1'(($urandom % 4) != 0), 8'($urandom), 2'($urandom_range(0, 3)),
                  1'(($urandom % 3) != 0));
        end
        for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 2'b00, 1'b1);

        // Reset in the middle of a full transfer.
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'hC0 + i), 2'b00, 1'b0);
        in_valid = 1'b1; s_in = 8'h99; out_ready = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check_eq("r38_valid", 32'(out_valid), 32'd0);
        check_eq("r38_count", 32'(count), 32'd0);
        check_eq("r38_in_ready", 32'(in_ready), 32'd1);
        check_eq("r38_bad", 32'(bad_sel), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        drive(1'b1, 8'h3C, 2'b00, 1'b0);
        check_eq("r38_first", 32'(s_out), 32'h3C);
        check_eq("r38_count1", 32'(count), 32'd1);
        drive(1'b0, 8'h00, 2'b00, 1'b1);

`ifdef ALU_RESULT_PARITY_EN
        drive(1'b1, 8'h07, 2'b00, 1'b0);
        check_eq("r39_par07", 32'(parity), 32'd1);
        drive(1'b1, 8'h03, 2'b00, 1'b1);
        check_eq("r39_par03", 32'(parity), 32'd0);
        drive(1'b0, 8'h00, 2'b00, 1'b1);
`endif

        for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 2'b00, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, number of buffered results (fixed at 4; pointer width 2).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port s_in  input  8  result from the ALU output mux.
REQ-005 The block SHALL have port ctrl_in  input  2  select code that produced s_in (00 compare, 01 andornot, 10 addsub).
REQ-006 The block SHALL have port in_valid  input  1  s_in/ctrl_in valid this cycle.
REQ-007 The block SHALL have port in_ready  output  1  buffer can accept an entry this cycle.
REQ-008 The block SHALL have port s_out  output  8  head-entry result.
REQ-009 The block SHALL have port ctrl_out  output  2  head-entry select code.
REQ-010 The block SHALL have port zero  output  1  head result equals 8'h00.
REQ-011 The block SHALL have port neg  output  1  bit 7 of head result.
REQ-012 The block SHALL have port out_valid  output  1  head entry present.
REQ-013 The block SHALL have port out_ready  input  1  consumer takes head this cycle.
REQ-014 The block SHALL have port count  output  3  entries held, 0..4.
REQ-015 The block SHALL have port bad_sel  output  1  sticky: an entry with ctrl_in 2'b11 was offered.

Function
REQ-016 Push SHALL occur on a clk edge when in_valid && in_ready && ctrl_in != 2'b11.
REQ-017 Pop SHALL occur on a clk edge when out_valid && out_ready.
REQ-018 in_ready SHALL be 1 exactly when count < 4; combinational from count only, never from out_ready (no full-state bypass).
REQ-019 State machine SHALL have states EMPTY (count 0), ACTIVE (count 1..3), FULL (count 4); EMPTY->ACTIVE on push; ACTIVE->FULL on push without pop at count 3; ACTIVE->EMPTY on pop without push at count 1; FULL->ACTIVE on pop; push and pop together leave count and state unchanged.
REQ-020 out_valid SHALL be 1 in ACTIVE and FULL, 0 in EMPTY.
REQ-021 Latency SHALL be 1 cycle: an entry pushed into EMPTY appears on s_out/ctrl_out with out_valid=1 in the cycle after the push edge.
REQ-022 Outputs SHALL present the head entry (show-ahead); after a pop the next entry appears in the following cycle with no bubble.
REQ-023 Read and write pointers SHALL be 2 bits and wrap 3->0.
REQ-024 zero and neg SHALL be computed when the entry is written and stored with it; they SHALL be 0 when out_valid is 0.
REQ-025 s_out and ctrl_out SHALL be 0 when out_valid is 0.
REQ-026 An offer with ctrl_in 2'b11 and in_valid=1 SHALL not be stored, SHALL not change count, and SHALL set bad_sel on that edge (when in_ready=1).
REQ-027 bad_sel SHALL stay 1 until reset.
REQ-028 Pop in EMPTY and push in FULL SHALL be impossible by construction; no entry is lost or duplicated.

Reset
REQ-029 rst=1 SHALL immediately force count=0, state EMPTY, pointers 0, out_valid=0, s_out=0, ctrl_out=0, zero=0, neg=0, bad_sel=0, in_ready=1.
REQ-030 rst asserted mid-operation SHALL discard all stored entries; no stale entry SHALL appear after rst deasserts.
REQ-031 Storage array contents SHALL not need reset.

Configuration
REQ-032 Macro ALU_RESULT_PARITY_EN, when defined, SHALL add output parity  output  1  even parity (XOR of 8 bits) of head result, stored per entry, 0 when out_valid=0, 0 on reset.
REQ-033 Without ALU_RESULT_PARITY_EN the parity port and its storage SHALL not exist; all other behaviour is identical.

Verification
REQ-034 Reset, push s_in=8'h00 ctrl_in=00 -> next cycle out_valid=1, s_out=8'h00, zero=1, neg=0, count=1.
REQ-035 Push 8'h81,8'h02,8'h7F,8'hFF (ctrl 10) with out_ready=0 -> count=4, in_ready=0; 5th offer ignored; then out_ready=1 -> 8'h81(neg=1),8'h02,8'h7F,8'hFF on consecutive cycles, count returns to 0.
REQ-036 At count=2, push and pop same cycle for 10 cycles -> count stays 2, FIFO order preserved across pointer wrap.
REQ-037 Offer ctrl_in=2'b11 s_in=8'h55 -> count unchanged, bad_sel=1 and remains 1 until rst.
REQ-038 Full FIFO, assert rst for one cycle mid-transfer -> out_valid=0, count=0, in_ready=1 immediately; first post-reset push 8'h3C is next s_out.
REQ-039 With ALU_RESULT_PARITY_EN, push 8'h07 -> parity=1; push 8'h03 -> parity=0.
